sfx_mixer: RTL and testbench
============================

Name: sfx_mixer

Overview:
- Parametrised multi-channel sound-effect generator.
- Each channel is a one-shot square-wave tone with a runtime-programmable half-period and duration.
- A fixed priority arbiter selects one channel to drive the single speaker pin.
- Sits between game-event logic (shot, collision, game-over, etc.) and the board speaker pin, and replaces the two-effect fixed-bit generator.

Parameters:
- NUM_CH, 4, number of effect channels; channel index = priority, highest index wins.
- CH_W, 2, width of the channel index output; must satisfy 2**CH_W >= NUM_CH.
- PER_W, 20, width of each half-period field, in clk cycles.
- DUR_W, 24, width of each duration field, in clk cycles.
- RETRIGGER, 0, 0 = a trigger on an active channel is ignored; 1 = it reloads the duration and restarts the tone.
- PREEMPT_CLEAR, 1, 1 = acceptance of a trigger cancels all lower-index active channels; 0 = lower channels keep counting underneath.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-low reset: sampled on the rising clk edge, asserted when 0.
- trig  in  NUM_CH  level-sensitive effect requests, one bit per channel.
- half_per  in  NUM_CH*PER_W  per-channel tone half-period; channel i occupies bits [i*PER_W +: PER_W].
- dur  in  NUM_CH*DUR_W  per-channel effect length in cycles; channel i occupies bits [i*DUR_W +: DUR_W].
- freeze  in  1  pause-and-mute: all state holds, pin forced low.
- pin  out  1  speaker output, registered.
- active  out  NUM_CH  per-channel remaining-count-nonzero flags, registered-derived.
- cur_ch  out  CH_W  index of the channel currently driving pin; 0 when idle.
- busy  out  1  OR of active.

Behaviour:
- Reset (rst==0 at a clk edge):
  - all remaining counters, tone counter and pin become 0.
  - active=0, cur_ch=0, busy=0.
  - Reset overrides freeze and trig, including mid-effect.
- Per channel i, remaining counter rem[i] (DUR_W bits); active[i] = (rem[i]!=0).
- Trigger acceptance at edge E, when freeze==0, trig[i]==1, dur[i]!=0, and (rem[i]==0 or RETRIGGER==1):
  - rem[i] <= dur[i].
  - dur[i]==0 means the trigger is ignored.
- Every other non-frozen edge: rem[i] <= rem[i]-1 if nonzero. A channel accepted at E0 is therefore active for exactly dur[i] edges and clears at edge E0+dur[i].
- PREEMPT_CLEAR==1: accepting channel i forces rem[j] <= 0 for all j<i at the same edge.
- Simultaneous triggers: all eligible channels load in the same cycle, and preemption clears apply.
- Selection: top = highest index with nonzero next-state rem; cur_ch registers top each edge. idle = no channel active.
- Tone counter tcnt (PER_W bits): it resets to 0 and pin <= 0 at any edge where any of these occur:
  - the selected channel changes (including idle to active);
  - the selected channel is accepted again via RETRIGGER;
  - the selected channel expires.
- Otherwise, while a channel c is selected and half_per[c]!=0:
  - if tcnt==half_per[c]-1, then pin toggles and tcnt <= 0;
  - else tcnt increments.
- Result: pin toggles at edges E0+k*half_per for k>=1 while the channel remains active.
- half_per[c]==0: the channel counts duration silently, with pin held 0.
- half_per changing mid-effect is honoured on the next compare; if tcnt already >= the new value-1, the toggle occurs at the next edge.
- Expiry: at the edge rem of the selected channel reaches 0, pin <= 0.
  - If a lower channel is still active (PREEMPT_CLEAR==0), it resumes from tcnt=0 on the same edge.
- freeze==1:
  - no acceptance, no decrement, tcnt holds;
  - pin output forced 0 combinationally from the registered value;
  - on release, pin returns to its held register value and counting resumes.
- Widths: all counters wrap-free by construction; there is no overflow path.

Test Plan:
- Reset mid-effect: NUM_CH=4, rst low for 1 edge during an active effect -> next cycle pin=0, active=0, busy=0, cur_ch=0; trig held during reset is not accepted until the first edge with rst==1.
- Single effect: trig[0] for 1 cycle at E0, half_per[0]=3, dur[0]=12 -> pin rises at E3, falls at E6, rises at E9, is 0 from E12; active[0] high E0..E11, clears at E12.
- Preemption: ch0 active (dur=100), trig[2] at E10 with half=2, dur=6 and PREEMPT_CLEAR=1 -> active[0] cleared at E10, cur_ch=2, pin toggles at E12/E14, idle from E16.
  - Same stimulus with PREEMPT_CLEAR=0 -> ch0 resumes at E16 with tcnt=0 and expires at E100.
- Retrigger: ch1 active, trig[1] re-pulsed at mid-effect -> with RETRIGGER=0, no change in expiry time; with RETRIGGER=1, rem reloads to dur[1] and pin is 0 at that edge.
- Freeze: freeze high for 5 cycles mid-effect -> pin=0 throughout, rem and tcnt unchanged, trig ignored; expiry delayed by exactly 5 cycles.
- Edge values: dur[i]=0 -> trigger ignored, busy stays 0; half_per[i]=0 with dur=8 -> active for 8 cycles with pin constantly 0; simultaneous trig=4'b1111 -> cur_ch=3 and, with PREEMPT_CLEAR=1, only active[3] is set.

Source files
------------

// File: rtl/sfx_mixer_if.sv
// Bundle of the sound-effect mixer request/response signals.
//   trig     : level-sensitive effect requests, one bit per channel
//   half_per : per-channel tone half-period, channel i at [i*PER_W +: PER_W]
//   dur      : per-channel effect length, channel i at [i*DUR_W +: DUR_W]
//   freeze   : pause all counting and mute the pin
//   pin      : speaker output
//   active   : per-channel remaining-count-nonzero flags
//   cur_ch   : channel currently driving pin (0 when idle)
//   busy     : any channel active
// master = game-event side, slave = mixer.
interface sfx_mixer_if #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CH_W   = 2,
  parameter int unsigned PER_W  = 20,
  parameter int unsigned DUR_W  = 24
);
  logic [NUM_CH-1:0]       trig;
  logic [NUM_CH*PER_W-1:0] half_per;
  logic [NUM_CH*DUR_W-1:0] dur;
  logic                    freeze;
  logic                    pin;
  logic [NUM_CH-1:0]       active;
  logic [CH_W-1:0]         cur_ch;
  logic                    busy;

  modport master (
    output trig, half_per, dur, freeze,
    input  pin, active, cur_ch, busy
  );

  modport slave (
    input  trig, half_per, dur, freeze,
    output pin, active, cur_ch, busy
  );
endinterface

// File: rtl/sfx_mixer.sv
// Multi-channel one-shot square-wave sound-effect generator.
// Each channel counts down a programmable duration; the highest-index active
// channel drives the speaker pin with a square wave of its programmed
// half-period.
//   clk : system clock
//   rst : synchronous active-low reset
//   bus : sfx_mixer_if slave (trig/half_per/dur/freeze in; pin/active/cur_ch/busy out)
module sfx_mixer #(
  parameter int unsigned NUM_CH        = 4,
  parameter int unsigned CH_W          = 2,
  parameter int unsigned PER_W         = 20,
  parameter int unsigned DUR_W         = 24,
  parameter int unsigned RETRIGGER     = 0,
  parameter int unsigned PREEMPT_CLEAR = 1
) (
  input logic        clk,
  input logic        rst,
  sfx_mixer_if.slave bus
);

  logic [DUR_W-1:0]  rem_q [NUM_CH];
  logic [DUR_W-1:0]  rem_d [NUM_CH];
  logic [PER_W-1:0]  tcnt_q, tcnt_d;
  logic              pin_q, pin_d;
  logic [CH_W-1:0]   cur_q, cur_d;

  logic [NUM_CH-1:0] acc;
  logic [NUM_CH-1:0] clr;
  logic [NUM_CH-1:0] active_now;
  logic              busy_now;
  logic              top_valid;
  logic [CH_W-1:0]   top_idx;
  logic [PER_W-1:0]  top_hp;
  logic              top_acc;
  logic              restart;

  // Current-state flags.
  always_comb begin
    active_now = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      active_now[i] = (rem_q[i] != '0);
    end
  end

  assign busy_now = |active_now;

  // Acceptance, preemption clears and next remaining counts.
  always_comb begin
    acc = '0;
    clr = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      acc[i] = !bus.freeze && bus.trig[i] && (bus.dur[i*DUR_W +: DUR_W] != '0) &&
               ((rem_q[i] == '0) || (RETRIGGER != 0));
    end
    for (int i = 0; i < NUM_CH; i++) begin
      clr[i] = (PREEMPT_CLEAR != 0) && (|(acc >> (i + 1)));
    end
    for (int i = 0; i < NUM_CH; i++) begin
      rem_d[i] = rem_q[i];
      if (!bus.freeze) begin
        // A higher accepted channel wins over a simultaneous lower load.
        if (clr[i]) begin
          rem_d[i] = '0;
        end else if (acc[i]) begin
          rem_d[i] = bus.dur[i*DUR_W +: DUR_W];
        end else if (rem_q[i] != '0) begin
          rem_d[i] = rem_q[i] - DUR_W'(1);
        end
      end
    end
  end

  // Selection: highest index with a nonzero next-state count.
  always_comb begin
    top_valid = 1'b0;
    top_idx   = '0;
    top_hp    = '0;
    top_acc   = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rem_d[i] != '0) begin
        top_valid = 1'b1;
        top_idx   = CH_W'(i);
        top_hp    = bus.half_per[i*PER_W +: PER_W];
        top_acc   = acc[i];
      end
    end
  end

  // The tone phase restarts on any selection change (idle<->active, preemption,
  // expiry handing over to a lower channel) and on a retrigger of the selected one.
  assign restart = (top_valid != busy_now) ||
                   (top_valid && (top_idx != cur_q)) ||
                   (top_valid && top_acc && busy_now && (top_idx == cur_q));

  always_comb begin
    tcnt_d = tcnt_q;
    pin_d  = pin_q;
    cur_d  = cur_q;
    if (!bus.freeze) begin
      cur_d = top_valid ? top_idx : '0;
      if (!top_valid || restart || (top_hp == '0)) begin
        tcnt_d = '0;
        pin_d  = 1'b0;
      end else if (tcnt_q >= top_hp - PER_W'(1)) begin
        // >= so a half-period shortened mid-effect toggles on the next edge.
        tcnt_d = '0;
        pin_d  = ~pin_q;
      end else begin
        tcnt_d = tcnt_q + PER_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        rem_q[i] <= '0;
      end
      tcnt_q <= '0;
      pin_q  <= 1'b0;
      cur_q  <= '0;
    end else begin
      rem_q  <= rem_d;
      tcnt_q <= tcnt_d;
      pin_q  <= pin_d;
      cur_q  <= cur_d;
    end
  end

  // Freeze mutes the pin without disturbing the held register value.
  assign bus.pin    = pin_q & ~bus.freeze;
  assign bus.active = active_now;
  assign bus.cur_ch = cur_q;
  assign bus.busy   = busy_now;

endmodule

// File: tb/tb_sfx_mixer.sv
// Bench for sfx_mixer: two instances (A: RETRIGGER=0/PREEMPT_CLEAR=1,
// B: RETRIGGER=1/PREEMPT_CLEAR=0) share directed stimulus; a behavioural model
// tracks remaining counts and the age of the current selection, from which the
// expected pin is (age / half_per) odd.
module tb_sfx_mixer;
  localparam int unsigned NUM_CH = 4;
  localparam int unsigned CH_W   = 2;
  localparam int unsigned PER_W  = 20;
  localparam int unsigned DUR_W  = 24;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [NUM_CH-1:0]       trig;
  logic [NUM_CH*PER_W-1:0] half_per;
  logic [NUM_CH*DUR_W-1:0] dur;
  logic                    freeze;

  always #5 clk = ~clk;

  sfx_mixer_if #(.NUM_CH(NUM_CH), .CH_W(CH_W), .PER_W(PER_W), .DUR_W(DUR_W)) bus_a ();
  sfx_mixer_if #(.NUM_CH(NUM_CH), .CH_W(CH_W), .PER_W(PER_W), .DUR_W(DUR_W)) bus_b ();

  assign bus_a.trig     = trig;
  assign bus_a.half_per = half_per;
  assign bus_a.dur      = dur;
  assign bus_a.freeze   = freeze;
  assign bus_b.trig     = trig;
  assign bus_b.half_per = half_per;
  assign bus_b.dur      = dur;
  assign bus_b.freeze   = freeze;

  sfx_mixer #(
    .NUM_CH(NUM_CH), .CH_W(CH_W), .PER_W(PER_W), .DUR_W(DUR_W),
    .RETRIGGER(0), .PREEMPT_CLEAR(1)
  ) u_a (
    .clk(clk),
    .rst(rst),
    .bus(bus_a)
  );

  sfx_mixer #(
    .NUM_CH(NUM_CH), .CH_W(CH_W), .PER_W(PER_W), .DUR_W(DUR_W),
    .RETRIGGER(1), .PREEMPT_CLEAR(0)
  ) u_b (
    .clk(clk),
    .rst(rst),
    .bus(bus_b)
  );

  int checks   = 0;
  int failures = 0;

  // Model state, index 0 = instance A, 1 = instance B.
  int unsigned m_rem [2][NUM_CH];
  bit          m_valid [2];
  int unsigned m_sel [2];
  int unsigned m_age [2];

  function automatic void check(input string name, input longint unsigned act,
                                input longint unsigned exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endfunction

  function automatic int unsigned hp_of(input int unsigned c);
    return 32'(half_per[c*PER_W +: PER_W]);
  endfunction

  function automatic int unsigned dur_of(input int unsigned c);
    return 32'(dur[c*DUR_W +: DUR_W]);
  endfunction

  task automatic set_ch(input int unsigned c, input int unsigned hp, input int unsigned d);
    half_per[c*PER_W +: PER_W] = PER_W'(hp);
    dur[c*DUR_W +: DUR_W]      = DUR_W'(d);
  endtask

  task automatic model_update(input int m);
    bit          retrig;
    bit          pclr;
    bit          acc [NUM_CH];
    int unsigned nrem [NUM_CH];
    bit          nvalid;
    int unsigned nsel;
    bit          restart;
    int          hi;
    retrig = (m == 1);
    pclr   = (m == 0);
    hi     = -1;
    if (!rst) begin
      for (int i = 0; i < NUM_CH; i++) m_rem[m][i] = 0;
      m_valid[m] = 0;
      m_sel[m]   = 0;
      m_age[m]   = 0;
      return;
    end
    if (freeze) return;
    for (int i = 0; i < NUM_CH; i++) begin
      acc[i] = trig[i] && (dur_of(i) != 0) && ((m_rem[m][i] == 0) || retrig);
      if (acc[i]) hi = i;
    end
    nvalid = 0;
    nsel   = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (pclr && hi > i)         nrem[i] = 0;
      else if (acc[i])            nrem[i] = dur_of(i);
      else if (m_rem[m][i] > 0)   nrem[i] = m_rem[m][i] - 1;
      else                        nrem[i] = 0;
      if (nrem[i] != 0) begin
        nvalid = 1;
        nsel   = i;
      end
    end
    restart = (nvalid != m_valid[m]) || (nvalid && nsel != m_sel[m]) ||
              (nvalid && acc[nsel]);
    m_age[m] = restart ? 0 : m_age[m] + 1;
    for (int i = 0; i < NUM_CH; i++) m_rem[m][i] = nrem[i];
    m_valid[m] = nvalid;
    m_sel[m]   = nsel;
  endtask

  task automatic compare_one(input int m, input string tag, input logic act_pin,
                             input logic [NUM_CH-1:0] act_active,
                             input logic [CH_W-1:0] act_cur, input logic act_busy);
    logic [NUM_CH-1:0] ea;
    int unsigned       hp;
    bit                ep;
    ea = '0;
    for (int i = 0; i < NUM_CH; i++) ea[i] = (m_rem[m][i] != 0);
    hp = m_valid[m] ? hp_of(m_sel[m]) : 0;
    ep = !freeze && m_valid[m] && (hp != 0) && (((m_age[m] / hp) % 2) == 1);
    check({tag, ".pin"}, 64'(act_pin), 64'(ep));
    check({tag, ".active"}, 64'(act_active), 64'(ea));
    check({tag, ".cur_ch"}, 64'(act_cur), 64'(m_valid[m] ? m_sel[m] : 0));
    check({tag, ".busy"}, 64'(act_busy), 64'(m_valid[m]));
  endtask

  // One clock: advance the model at the edge, compare both DUTs half a cycle later.
  task automatic step();
    @(posedge clk);
    model_update(0);
    model_update(1);
    @(negedge clk);
    compare_one(0, "a", bus_a.pin, bus_a.active, bus_a.cur_ch, bus_a.busy);
    compare_one(1, "b", bus_b.pin, bus_b.active, bus_b.cur_ch, bus_b.busy);
  endtask

  initial begin
    rst      = 1'b0;
    trig     = '0;
    freeze   = 1'b0;
    half_per = '0;
    dur      = '0;
    step();
    step();
    check("reset.busy", 64'(bus_a.busy), 64'(0));
    check("reset.pin", 64'(bus_a.pin), 64'(0));
    rst = 1'b1;

    // Single effect: half 3, dur 12.
    set_ch(0, 3, 12);
    trig = 4'b0001;
    step();
    trig = '0;
    check("single.busy_e0", 64'(bus_a.busy), 64'(1));
    for (int k = 1; k <= 14; k++) begin
      step();
      if (k == 3)  check("single.pin_e3", 64'(bus_a.pin), 64'(1));
      if (k == 6)  check("single.pin_e6", 64'(bus_a.pin), 64'(0));
      if (k == 9)  check("single.pin_e9", 64'(bus_a.pin), 64'(1));
      if (k == 11) check("single.act_e11", 64'(bus_a.active), 64'(1));
      if (k == 12) check("single.act_e12", 64'(bus_a.active), 64'(0));
      if (k == 12) check("single.pin_e12", 64'(bus_a.pin), 64'(0));
    end

    // Preemption: ch0 dur 100, ch2 at E10 half 2 dur 6.
    set_ch(0, 5, 100);
    set_ch(2, 2, 6);
    trig = 4'b0001;
    step();
    trig = '0;
    for (int k = 1; k <= 9; k++) step();
    trig = 4'b0100;
    step();
    trig = '0;
    check("preempt.a_act0_e10", 64'(bus_a.active[0]), 64'(0));
    check("preempt.a_cur_e10", 64'(bus_a.cur_ch), 64'(2));
    check("preempt.b_act0_e10", 64'(bus_b.active[0]), 64'(1));
    check("preempt.b_cur_e10", 64'(bus_b.cur_ch), 64'(2));
    for (int k = 11; k <= 102; k++) begin
      step();
      if (k == 12)  check("preempt.a_pin_e12", 64'(bus_a.pin), 64'(1));
      if (k == 14)  check("preempt.a_pin_e14", 64'(bus_a.pin), 64'(0));
      if (k == 16)  check("preempt.a_busy_e16", 64'(bus_a.busy), 64'(0));
      if (k == 16)  check("preempt.b_cur_e16", 64'(bus_b.cur_ch), 64'(0));
      if (k == 16)  check("preempt.b_busy_e16", 64'(bus_b.busy), 64'(1));
      if (k == 99)  check("preempt.b_busy_e99", 64'(bus_b.busy), 64'(1));
      if (k == 100) check("preempt.b_busy_e100", 64'(bus_b.busy), 64'(0));
    end

    // Retrigger: ch1 half 3 dur 20, re-pulsed at E9.
    set_ch(1, 3, 20);
    trig = 4'b0010;
    step();
    trig = '0;
    for (int k = 1; k <= 8; k++) step();
    trig = 4'b0010;
    step();
    trig = '0;
    check("retrig.a_pin_e9", 64'(bus_a.pin), 64'(1));
    check("retrig.b_pin_e9", 64'(bus_b.pin), 64'(0));
    for (int k = 10; k <= 31; k++) begin
      step();
      if (k == 19) check("retrig.a_busy_e19", 64'(bus_a.busy), 64'(1));
      if (k == 20) check("retrig.a_busy_e20", 64'(bus_a.busy), 64'(0));
      if (k == 28) check("retrig.b_busy_e28", 64'(bus_b.busy), 64'(1));
      if (k == 29) check("retrig.b_busy_e29", 64'(bus_b.busy), 64'(0));
    end

    // Freeze for edges E6..E10 with a trigger on ch3 that must be ignored.
    set_ch(3, 3, 5);
    trig = 4'b0010;
    step();
    trig = '0;
    for (int k = 1; k <= 5; k++) step();
    freeze = 1'b1;
    for (int k = 6; k <= 10; k++) begin
      if (k == 7) trig = 4'b1000;
      step();
      trig = '0;
      check("freeze.a_pin", 64'(bus_a.pin), 64'(0));
      check("freeze.a_active", 64'(bus_a.active), 64'(4'b0010));
    end
    freeze = 1'b0;
    #1;
    check("freeze.a_pin_release", 64'(bus_a.pin), 64'(1));
    for (int k = 11; k <= 27; k++) begin
      step();
      if (k == 24) check("freeze.a_busy_e24", 64'(bus_a.busy), 64'(1));
      if (k == 25) check("freeze.a_busy_e25", 64'(bus_a.busy), 64'(0));
    end

    // Zero duration is ignored.
    set_ch(0, 3, 0);
    trig = 4'b0001;
    step();
    trig = '0;
    check("dur0.a_busy", 64'(bus_a.busy), 64'(0));
    check("dur0.b_busy", 64'(bus_b.busy), 64'(0));

    // Zero half-period: silent for 8 cycles.
    set_ch(2, 0, 8);
    trig = 4'b0100;
    step();
    trig = '0;
    for (int k = 1; k <= 9; k++) begin
      step();
      check("hp0.a_pin", 64'(bus_a.pin), 64'(0));
      if (k == 7) check("hp0.a_busy_e7", 64'(bus_a.busy), 64'(1));
      if (k == 8) check("hp0.a_busy_e8", 64'(bus_a.busy), 64'(0));
    end

    // Simultaneous triggers on all channels.
    for (int c = 0; c < NUM_CH; c++) set_ch(c, 2, 10);
    trig = 4'b1111;
    step();
    trig = '0;
    check("simul.a_active", 64'(bus_a.active), 64'(4'b1000));
    check("simul.a_cur", 64'(bus_a.cur_ch), 64'(3));
    check("simul.b_active", 64'(bus_b.active), 64'(4'b1111));
    check("simul.b_cur", 64'(bus_b.cur_ch), 64'(3));
    for (int k = 1; k <= 12; k++) step();

    // Reset mid-effect with trig held through reset.
    set_ch(1, 3, 20);
    trig = 4'b0010;
    step();
    trig = '0;
    for (int k = 1; k <= 4; k++) step();
    rst  = 1'b0;
    trig = 4'b0010;
    step();
    check("rstmid.a_pin", 64'(bus_a.pin), 64'(0));
    check("rstmid.a_active", 64'(bus_a.active), 64'(0));
    check("rstmid.a_busy", 64'(bus_a.busy), 64'(0));
    check("rstmid.a_cur", 64'(bus_a.cur_ch), 64'(0));
    rst = 1'b1;
    step();
    check("rstmid.a_busy_after", 64'(bus_a.busy), 64'(1));
    trig = '0;
    for (int k = 0; k < 25; k++) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
